// File: rtl/nand_rr_scheduler.sv
// Round-robin front end for a single bit-serial NAND evaluator shared by NREQ requesters.
// Each grant latches one WIDTH-bit operand and returns ~&operand, tagged with the requester id.
module nand_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic                    rsp_y
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        EVAL = 1'b1
    } state_t;

    state_t             state, state_nx;
    logic [IDW-1:0]     ptr, ptr_nx;
    logic [IDW-1:0]     id, id_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic               acc, acc_nx;
    logic [WIDTH-1:0]   opnd, opnd_nx;
    logic [NREQ-1:0]    gnt_nx;
    logic               rsp_valid_nx;
    logic [IDW-1:0]     rsp_id_nx;
    logic               rsp_y_nx;

    logic               found;
    logic [IDW-1:0]     sel;
    logic [IDW-1:0]     cand;
    logic [WIDTH-1:0]   sel_data;
    int                 idx;

    // Circular search starting at ptr; the first requester found wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = IDW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (sel == IDW'(k)) begin
                sel_data = req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        id_nx        = id;
        cnt_nx       = cnt;
        acc_nx       = acc;
        opnd_nx      = opnd;
        gnt_nx       = '0;
        rsp_valid_nx = 1'b0;
        rsp_id_nx    = rsp_id;
        rsp_y_nx     = rsp_y;

        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nx   = NREQ'(1) << sel;
                    id_nx    = sel;
                    opnd_nx  = sel_data;
                    acc_nx   = 1'b1;
                    cnt_nx   = '0;
                    state_nx = EVAL;
                end
            end

            EVAL: begin
                // One AND step per cycle, LSB first, no early exit on a zero bit.
                acc_nx = acc & opnd[cnt];
                cnt_nx = cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    rsp_y_nx     = ~(acc & opnd[WIDTH-1]);
                    rsp_valid_nx = 1'b1;
                    rsp_id_nx    = id;
                    ptr_nx       = (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
                    state_nx     = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            id        <= '0;
            cnt       <= '0;
            acc       <= 1'b1;
            opnd      <= '0;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            id        <= id_nx;
            cnt       <= cnt_nx;
            acc       <= acc_nx;
            opnd      <= opnd_nx;
            gnt       <= gnt_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_id    <= rsp_id_nx;
            rsp_y     <= rsp_y_nx;
        end
    end

    assign busy = (state == EVAL);

endmodule
